serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder_pkg.sv | 13 +
 rtl/full_adder.sv | 13 +
 rtl/serial_adder.sv | 118 +++++++++++
 tb/tb_serial_adder.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encodings and
// the default operand width.
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder, the per-bit arithmetic cell of the serial adder.
module full_adder (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = x ^ y ^ cin;
    assign cout = (x & y) | (cin & (x ^ y));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: adds a + b + cin one bit per clock, LSB first, and
// presents a registered sum/cout with a one-cycle done pulse.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int                CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WIDTH - 1);

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_sr_q, a_sr_d;
    logic [WIDTH-1:0]  b_sr_q, b_sr_d;
    // Holds the WIDTH-1 sum bits produced so far; the final bit joins them
    // directly on the way into sum_q.
    logic [WIDTH-2:0]  res_sr_q, res_sr_d;
    logic [WIDTH-1:0]  res_ext;
    logic              carry_q, carry_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              cout_q, cout_d;
    logic              fa_sum, fa_cout;

    full_adder u_fa (
        .x    (a_sr_q[0]),
        .y    (b_sr_q[0]),
        .cin  (carry_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    assign res_ext = {fa_sum, res_sr_q};

    always_comb begin
        // NOTE: every signal assigned in this block gets a default first, so
        // no path through the case can leave one unassigned and infer a latch.
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        res_sr_d = res_sr_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        sum_d    = sum_q;
        cout_d   = cout_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_sr_d  = a;
                    b_sr_d  = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                res_sr_d = res_ext[WIDTH-1:1];
                carry_d  = fa_cout;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST_BIT) begin
                    sum_d   = res_ext;
                    cout_d  = fa_cout;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            res_sr_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            res_sr_q <= res_sr_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
        end
    end

    assign busy = (state_q == SHIFT);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8): directed corner cases,
// start/operand interference, mid-operation reset and random back-to-back adds.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int checks        = 0;
    int errors        = 0;
    int cyc           = 0;
    int accept_cyc    = 0;
    int last_done_cyc = 0;

    logic [W:0] sb[$];
    logic [W:0] last_res;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; waits until the DUT is idle, then issues one add.
    task automatic start_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b, input logic op_cin);
        int         guard;
        logic [W:0] exp;
        a     = op_a;
        b     = op_b;
        cin   = op_cin;
        start = 1'b1;
        guard = 0;
        while ((busy || done) && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("idle_before_start", 64'({busy, done}), 64'(0));
        @(posedge clk);
        exp = (W+1)'(op_a) + (W+1)'(op_b) + (W+1)'(op_cin);
        sb.push_back(exp);
        @(negedge clk);
        accept_cyc = cyc;
        start      = 1'b0;
        a          = ~op_a;
        b          = W'($urandom);
        cin        = ~op_cin;
        check("accept_busy", 64'(busy), 64'(1));
    endtask

    // Waits (bounded) for done, checking busy and the held previous result meanwhile.
    task automatic wait_done(input bit chk_space);
        bit         seen;
        logic [W:0] exp;
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
            end else begin
                check("busy_during_op", 64'(busy), 64'(1));
                check("hold_prev_result", 64'({cout, sum}), 64'(last_res));
            end
        end
        check("done_seen", 64'(seen), 64'(1));
        if (seen) begin
            check("latency", 64'(cyc - accept_cyc), 64'(W));
            check("busy_low_in_done", 64'(busy), 64'(0));
            check("scoreboard_depth", 64'(sb.size()), 64'(1));
            if (sb.size() > 0) begin
                exp = sb.pop_front();
                check("result", 64'({cout, sum}), 64'(exp));
                last_res = exp;
            end
            if (chk_space) check("done_spacing", 64'(cyc - last_done_cyc), 64'(W + 2));
            last_done_cyc = cyc;
        end
    endtask

    initial begin
        rst_n    = 1'b1;
        start    = 1'b0;
        a        = '0;
        b        = '0;
        cin      = 1'b0;
        last_res = '0;

        #1 rst_n = 1'b0;
        #1 check("reset_state", 64'({busy, done, cout, sum}), 64'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // First start right after reset release, zero operands.
        start_op(8'h00, 8'h00, 1'b0);
        wait_done(1'b0);
        @(negedge clk);
        check("done_one_cycle", 64'({busy, done}), 64'(0));

        // Carry out of the top bit, then carry into the top bit only.
        start_op(8'hFF, 8'h01, 1'b0);
        wait_done(1'b0);
        start_op(8'h7F, 8'h01, 1'b0);
        wait_done(1'b0);
        start_op(8'hA5, 8'h5A, 1'b1);
        wait_done(1'b0);

        // start with new operands during SHIFT and DONE must be ignored.
        start_op(8'h3C, 8'h0F, 1'b0);
        repeat (2) @(negedge clk);
        start = 1'b1;
        a     = 8'hFF;
        b     = 8'hFF;
        cin   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(1'b0);
        start = 1'b1;
        a     = 8'h11;
        b     = 8'h22;
        @(negedge clk);
        check("start_ignored_in_done", 64'({busy, done}), 64'(0));
        start = 1'b0;
        @(negedge clk);
        check("stay_idle", 64'({busy, done}), 64'(0));
        start_op(8'h11, 8'h22, 1'b0);
        wait_done(1'b0);

        // Reset between edges after four SHIFT edges.
        start_op(8'hC8, 8'h64, 1'b1);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("reset_abort", 64'({busy, done, cout, sum}), 64'(0));
        sb.delete();
        last_res = '0;
        repeat (3) begin
            @(negedge clk);
            check("quiet_in_reset", 64'({busy, done, cout, sum}), 64'(0));
        end
        rst_n = 1'b1;
        start_op(8'hC8, 8'h64, 1'b1);
        wait_done(1'b0);

        // Random back-to-back operations.
        for (int i = 0; i < 1000; i++) begin
            start_op(W'($urandom), W'($urandom), 1'($urandom));
            wait_done(i > 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
